ddr_rd_arbiter: RTL and testbench
=================================

# ddr_rd_arbiter

Shares the single DDR read channel between the weight, bias and data fetch controllers (wfc, bfc, dfc) that the top controller configures. It accepts burst read requests, issues one DDR read command at a time under round-robin arbitration, and routes the returned beats back to the owning fetcher. There is exactly one outstanding transaction at any time.

## Interface
Parameters:
- N_REQ, 3, number of requesters; index 0 = wfc, 1 = bfc, 2 = dfc.
- DDR_ADDR_LEN, 32, DDR byte address width.
- DATA_W, 128, DDR read data width.
- LEN_W, 8, burst length field; the value is beats-1, so at most 256 beats.

Ports:
- clk  in  1  clock. One clock domain; reset is asynchronous and active-low.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  request accepted (one-hot, one cycle).
- req_addr  in  N_REQ*DDR_ADDR_LEN  packed start addresses; requester i uses slice i.
- req_len  in  N_REQ*LEN_W  packed burst lengths (beats-1).
- ddr_ar_valid  out  1  DDR read command valid.
- ddr_ar_ready  in  1  DDR read command accepted.
- ddr_ar_addr  out  DDR_ADDR_LEN  command address.
- ddr_ar_len  out  LEN_W  command length.
- ddr_r_valid  in  1  read beat valid.
- ddr_r_data  in  DATA_W  read beat data.
- ddr_r_last  in  1  last beat, as flagged by DDR.
- ddr_r_ready  out  1  read beat accepted.
- rsp_valid  out  N_REQ  beat valid; only the granted requester's bit can be high.
- rsp_data  out  DATA_W  beat data, broadcast to all requesters.
- rsp_last  out  1  last beat, taken from the internal counter.
- rsp_ready  in  N_REQ  per-requester beat ready.
- grant  out  N_REQ  one-hot owner of the current transaction; all zero when idle.
- busy  out  1  high in any state other than IDLE.
- err_last  out  1  sticky: ddr_r_last disagreed with the beat counter.

## Operation
States:
- IDLE. The round-robin pick looks at req_valid, starting from last_grant+1 and wrapping. The winner w gets req_ready[w]=1 in the same cycle (combinational).
  - At that edge: latch addr_r, len_r and cnt<=req_len[w]; set grant<=onehot(w) and last_grant<=w; go to CMD.
  - With no valid request, stay in IDLE.
- CMD. ddr_ar_valid=1, with ddr_ar_addr/ddr_ar_len driven from the registers and held stable. On ddr_ar_ready, go to DATA.
- DATA. The R channel passes through combinationally to the granted requester:
  - rsp_valid[g]=ddr_r_valid and ddr_r_ready=rsp_ready[g]; rsp_data=ddr_r_data; rsp_last=(cnt==0).
  - On each handshake: if cnt==0, go to IDLE and clear grant; otherwise decrement cnt.
  - If ddr_r_last != (cnt==0) on a handshake, set err_last. The counter still governs termination.
- A requester may drop req_valid before it is accepted; it is simply not selected. req_addr/req_len only need to be stable in the accept cycle.
- ddr_r_ready=0 and rsp_valid=0 in IDLE and CMD. Beats arriving then are not accepted.
- Reset values: all outputs 0, state IDLE, cnt=0, last_grant=N_REQ-1 (so requester 0 wins first), err_last=0.
- Reset asserted mid-transaction aborts immediately to the reset state. Draining the DDR side is the system's responsibility.

## Timing
- Request accept to ddr_ar_valid: 1 cycle.
- AR handshake to first rsp_valid: depends on DDR latency; zero added latency on the R path.
- Last beat handshake to IDLE: 1 cycle. The next grant's req_ready can assert in that IDLE cycle, so there is a minimum 1-cycle bubble between a last beat and the next request accept.
- Minimum transaction length: 1 (AR) + 1 (R) + 1 (IDLE) = 3 cycles.
- Simultaneous requests: round-robin order. A requester that has just been served has the lowest priority, so a continuously-requesting fetcher cannot starve the others.

## Structure
- Shared package ddr_arb_pkg:
  - state enum {IDLE, CMD, DATA};
  - requester index constants REQ_WFC=0, REQ_BFC=1, REQ_DFC=2;
  - default widths.
- Sub-module rr_arbiter: N_REQ-wide one-hot round-robin pick from a request vector and a last-grant pointer. It is purely combinational and reusable by the write-back path.
- Top-level logic: the FSM, the address/length/count registers and the R-channel mux.

## Test plan
- Single request: dfc only, addr=0x1000, len=3, ddr_ar_ready high, R beats back-to-back.
  - Required: ddr_ar_valid 1 cycle after accept with addr 0x1000, len 3.
  - Required: exactly 4 beats on rsp_valid[2], rsp_last on the 4th, grant=3'b100 throughout, then busy falls.
- All three requesting from reset, len=0 each: grant order wfc, bfc, dfc. A repeated wfc request goes after dfc.
- Backpressure:
  - ddr_ar_ready held low for 5 cycles: ar addr/len stay stable.
  - rsp_ready[0] toggling during an 8-beat burst: ddr_r_ready mirrors it, and the beat count is still 8 accepted handshakes.
- ddr_r_last asserted early, on beat 2 of len=3: err_last sets and stays set, and the transaction still ends after 4 beats.
- Reset mid-DATA, after 2 of 4 beats: all outputs 0 asynchronously and state IDLE. After release, wfc is granted first.
- req_valid[1] pulsed for 1 cycle while busy: it is not granted and no extra AR is issued.

Source files
------------

// File: rtl/ddr_rd_arbiter_pkg.sv
// Shared types and constants for the DDR read-channel arbiter.
// Also intended for reuse by the write-back path.
package ddr_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } state_e;

    localparam int REQ_WFC = 0;
    localparam int REQ_BFC = 1;
    localparam int REQ_DFC = 2;

    localparam int N_REQ_DEF        = 3;
    localparam int DDR_ADDR_LEN_DEF = 32;
    localparam int DATA_W_DEF       = 128;
    localparam int LEN_W_DEF        = 8;

endpackage

// File: rtl/ddr_rd_arbiter_rr_arbiter.sv
// Combinational round-robin pick: search starts at last_idx+1 and wraps,
// so the most recently served requester has the lowest priority.
module rr_arbiter #(
    parameter int N_REQ = 3,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_idx,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld
);

    int idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        idx     = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(last_idx) + k) % N_REQ;
            if (!gnt_vld && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = IDX_W'(idx);
                gnt_vld  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ddr_rd_arbiter.sv
// Shares the single DDR read channel between the fetch controllers: one
// outstanding burst at a time, beats routed back to the granted requester.
module ddr_rd_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int N_REQ        = N_REQ_DEF,
    parameter int DDR_ADDR_LEN = DDR_ADDR_LEN_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int LEN_W        = LEN_W_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_REQ-1:0]              req_valid,
    output logic [N_REQ-1:0]              req_ready,
    input  logic [N_REQ*DDR_ADDR_LEN-1:0] req_addr,
    input  logic [N_REQ*LEN_W-1:0]        req_len,
    output logic                          ddr_ar_valid,
    input  logic                          ddr_ar_ready,
    output logic [DDR_ADDR_LEN-1:0]       ddr_ar_addr,
    output logic [LEN_W-1:0]              ddr_ar_len,
    input  logic                          ddr_r_valid,
    input  logic [DATA_W-1:0]             ddr_r_data,
    input  logic                          ddr_r_last,
    output logic                          ddr_r_ready,
    output logic [N_REQ-1:0]              rsp_valid,
    output logic [DATA_W-1:0]             rsp_data,
    output logic                          rsp_last,
    input  logic [N_REQ-1:0]              rsp_ready,
    output logic [N_REQ-1:0]              grant,
    output logic                          busy,
    output logic                          err_last
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_e                  state_q, state_d;
    logic [DDR_ADDR_LEN-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]        len_q, len_d;
    logic [LEN_W-1:0]        cnt_q, cnt_d;
    logic [N_REQ-1:0]        grant_q, grant_d;
    logic [IDX_W-1:0]        last_grant_q, last_grant_d;
    logic                    err_last_q, err_last_d;

    logic [N_REQ-1:0]        pick_gnt;
    logic [IDX_W-1:0]        pick_idx;
    logic                    pick_vld;

    rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_rr (
        .req      (req_valid),
        .last_idx (last_grant_q),
        .gnt      (pick_gnt),
        .gnt_idx  (pick_idx),
        .gnt_vld  (pick_vld)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        err_last_d   = err_last_q;
        req_ready    = '0;
        ddr_ar_valid = 1'b0;
        ddr_r_ready  = 1'b0;
        rsp_valid    = '0;
        rsp_data     = '0;
        rsp_last     = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    req_ready    = pick_gnt;
                    addr_d       = req_addr[int'(pick_idx)*DDR_ADDR_LEN +: DDR_ADDR_LEN];
                    len_d        = req_len[int'(pick_idx)*LEN_W +: LEN_W];
                    cnt_d        = req_len[int'(pick_idx)*LEN_W +: LEN_W];
                    grant_d      = pick_gnt;
                    last_grant_d = pick_idx;
                    state_d      = CMD;
                end
            end
            CMD: begin
                ddr_ar_valid = 1'b1;
                if (ddr_ar_ready) state_d = DATA;
            end
            DATA: begin
                rsp_valid   = grant_q & {N_REQ{ddr_r_valid}};
                ddr_r_ready = |(rsp_ready & grant_q);
                rsp_data    = ddr_r_data;
                rsp_last    = (cnt_q == '0);
                // The beat counter, not ddr_r_last, decides where the burst ends.
                if (ddr_r_valid && ddr_r_ready) begin
                    if (ddr_r_last != rsp_last) err_last_d = 1'b1;
                    if (rsp_last) begin
                        state_d = IDLE;
                        grant_d = '0;
                    end else begin
                        cnt_d = cnt_q - LEN_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            len_q        <= '0;
            cnt_q        <= '0;
            grant_q      <= '0;
            last_grant_q <= IDX_W'(N_REQ - 1);
            err_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            err_last_q   <= err_last_d;
        end
    end

    assign ddr_ar_addr = addr_q;
    assign ddr_ar_len  = len_q;
    assign grant       = grant_q;
    assign busy        = (state_q != IDLE);
    assign err_last    = err_last_q;

endmodule

// File: tb/tb_ddr_rd_arbiter.sv
// Self-checking bench for ddr_rd_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level round-robin model.
module tb_ddr_rd_arbiter;

    logic          clk, rst_n;
    logic [2:0]    req_valid, req_ready;
    logic [95:0]   req_addr;
    logic [23:0]   req_len;
    logic          ddr_ar_valid, ddr_ar_ready;
    logic [31:0]   ddr_ar_addr;
    logic [7:0]    ddr_ar_len;
    logic          ddr_r_valid, ddr_r_last, ddr_r_ready;
    logic [127:0]  ddr_r_data, rsp_data;
    logic [2:0]    rsp_valid, rsp_ready, grant;
    logic          rsp_last, busy, err_last;

    int errors = 0;
    int checks = 0;
    int last_m = 2;
    bit err_m  = 1'b0;

    ddr_rd_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_len(req_len),
        .ddr_ar_valid(ddr_ar_valid), .ddr_ar_ready(ddr_ar_ready),
        .ddr_ar_addr(ddr_ar_addr), .ddr_ar_len(ddr_ar_len),
        .ddr_r_valid(ddr_r_valid), .ddr_r_data(ddr_r_data),
        .ddr_r_last(ddr_r_last), .ddr_r_ready(ddr_r_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last),
        .rsp_ready(rsp_ready), .grant(grant), .busy(busy), .err_last(err_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Round-robin rule: search from the last served index + 1, wrapping.
    function automatic int pick(input logic [2:0] r, input int last);
        int i;
        for (int k = 1; k <= 3; k++) begin
            i = (last + k) % 3;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    // ready_mode: 0 all ready, 1 owner's ready toggles, 2 random.
    task automatic run_txn(input logic [2:0] reqv, input int exp_w, input logic [31:0] addr,
                           input logic [7:0] len, input int ar_wait, input int ready_mode,
                           input bit rvalid_rand, input int early, input int abort_after,
                           input bit pulse);
        logic [2:0] oh;
        int beat, cyc;
        oh = 3'b001 << exp_w;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            req_addr[i*32 +: 32] = $urandom;
            req_len[i*8 +: 8]    = 8'($urandom);
        end
        req_addr[exp_w*32 +: 32] = addr;
        req_len[exp_w*8 +: 8]    = len;
        req_valid = reqv; ddr_r_valid = 1'b0; ddr_ar_ready = 1'b0; rsp_ready = 3'b000;
        #1;
        checks++; if (req_ready !== oh) begin errors++; $display("FAIL accept_ready: got %b exp %b", req_ready, oh); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL accept_busy: got %b exp 0", busy); end
        last_m = exp_w;

        @(negedge clk);
        req_valid = 3'b000; ddr_r_valid = 1'b1; rsp_ready = 3'b111;
        #1;
        checks++; if (ddr_ar_valid !== 1'b1 || ddr_ar_addr !== addr || ddr_ar_len !== len) begin
            errors++; $display("FAIL ar_cmd: got v=%b a=%h l=%0d exp v=1 a=%h l=%0d", ddr_ar_valid, ddr_ar_addr, ddr_ar_len, addr, len); end
        checks++; if (grant !== oh || busy !== 1'b1) begin errors++; $display("FAIL cmd_grant: got g=%b busy=%b exp g=%b busy=1", grant, busy, oh); end
        checks++; if (ddr_r_ready !== 1'b0 || rsp_valid !== 3'b000) begin
            errors++; $display("FAIL cmd_no_beat: got r_ready=%b rsp_valid=%b exp 0/000", ddr_r_ready, rsp_valid); end
        for (int i = 0; i < ar_wait; i++) begin
            @(negedge clk); #1;
            checks++; if (ddr_ar_valid !== 1'b1 || ddr_ar_addr !== addr || ddr_ar_len !== len) begin
                errors++; $display("FAIL ar_stable: got v=%b a=%h l=%0d exp v=1 a=%h l=%0d", ddr_ar_valid, ddr_ar_addr, ddr_ar_len, addr, len); end
        end
        @(negedge clk);
        ddr_ar_ready = 1'b1; ddr_r_valid = 1'b0;
        #1;
        checks++; if (ddr_ar_valid !== 1'b1) begin errors++; $display("FAIL ar_hs: got %b exp 1", ddr_ar_valid); end

        beat = 0; cyc = 0;
        while (beat <= int'(len) && cyc < 600) begin
            @(negedge clk);
            ddr_ar_ready = 1'b0;
            ddr_r_valid  = rvalid_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            ddr_r_data   = {$urandom, $urandom, $urandom, $urandom};
            ddr_r_last   = (early >= 0) ? (beat == early) : (beat == int'(len));
            case (ready_mode)
                0: rsp_ready = 3'b111;
                1: begin rsp_ready = 3'($urandom); rsp_ready[exp_w] = (cyc % 2 == 0); end
                default: rsp_ready = 3'($urandom);
            endcase
            req_valid = (pulse && cyc == 0) ? 3'b010 : 3'b000;
            #1;
            checks++; if (rsp_valid !== (ddr_r_valid ? oh : 3'b000)) begin
                errors++; $display("FAIL rsp_valid: got %b exp %b beat %0d", rsp_valid, ddr_r_valid ? oh : 3'b000, beat); end
            checks++; if (rsp_data !== ddr_r_data) begin errors++; $display("FAIL rsp_data: got %h exp %h", rsp_data, ddr_r_data); end
            checks++; if (rsp_last !== (beat == int'(len))) begin
                errors++; $display("FAIL rsp_last: got %b exp %b beat %0d", rsp_last, beat == int'(len), beat); end
            checks++; if (ddr_r_ready !== rsp_ready[exp_w]) begin
                errors++; $display("FAIL r_ready: got %b exp %b", ddr_r_ready, rsp_ready[exp_w]); end
            checks++; if (grant !== oh || busy !== 1'b1 || err_last !== err_m) begin
                errors++; $display("FAIL data_state: got g=%b busy=%b err=%b exp g=%b busy=1 err=%b", grant, busy, err_last, oh, err_m); end
            checks++; if (ddr_ar_valid !== 1'b0 || req_ready !== 3'b000) begin
                errors++; $display("FAIL data_no_new_req: got ar_v=%b req_ready=%b exp 0/000", ddr_ar_valid, req_ready); end
            if (ddr_r_valid && rsp_ready[exp_w]) begin
                if (ddr_r_last != (beat == int'(len))) err_m = 1'b1;
                beat++;
            end
            cyc++;
            if (beat == abort_after) return;
        end
        if (cyc >= 600) begin errors++; $display("FAIL beat_timeout: got %0d beats exp %0d", beat, int'(len) + 1); end

        @(negedge clk);
        ddr_r_valid = 1'b0; ddr_r_last = 1'b0; req_valid = 3'b000;
        #1;
        checks++; if (busy !== 1'b0 || grant !== 3'b000 || ddr_ar_valid !== 1'b0) begin
            errors++; $display("FAIL end_idle: got busy=%b g=%b ar_v=%b exp 0/000/0", busy, grant, ddr_ar_valid); end
        checks++; if (err_last !== err_m) begin errors++; $display("FAIL end_err_last: got %b exp %b", err_last, err_m); end
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if (req_ready !== 0 || ddr_ar_valid !== 0 || ddr_ar_addr !== 0 || ddr_ar_len !== 0 ||
            ddr_r_ready !== 0 || rsp_valid !== 0 || rsp_data !== 0 || rsp_last !== 0 ||
            grant !== 0 || busy !== 0 || err_last !== 0) begin
            errors++;
            $display("FAIL %s: got rr=%b arv=%b ara=%h arl=%0d rr=%b rv=%b rd=%h rl=%b g=%b busy=%b err=%b exp all 0",
                     tag, req_ready, ddr_ar_valid, ddr_ar_addr, ddr_ar_len, ddr_r_ready, rsp_valid,
                     rsp_data, rsp_last, grant, busy, err_last);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 0; req_addr = 0; req_len = 0; ddr_ar_ready = 0;
        ddr_r_valid = 0; ddr_r_data = 0; ddr_r_last = 0; rsp_ready = 0;
        repeat (2) @(negedge clk);
        #1 check_all_zero("reset_outputs");
        @(negedge clk);
        rst_n = 1'b1; last_m = 2; err_m = 1'b0;
    endtask

    task automatic test_single();
        run_txn(3'b100, 2, 32'h1000, 8'd3, 0, 0, 1'b0, -1, -1, 1'b0);
    endtask

    task automatic test_round_robin();
        run_txn(3'b111, 0, 32'h2000, 8'd0, 0, 0, 1'b0, -1, -1, 1'b0);
        run_txn(3'b111, 1, 32'h2100, 8'd0, 0, 0, 1'b0, -1, -1, 1'b0);
        run_txn(3'b111, 2, 32'h2200, 8'd0, 0, 0, 1'b0, -1, -1, 1'b0);
        run_txn(3'b111, 0, 32'h2300, 8'd0, 0, 0, 1'b0, -1, -1, 1'b0);
        run_txn(3'b101, 2, 32'h2400, 8'd0, 0, 0, 1'b0, -1, -1, 1'b0);
    endtask

    task automatic test_backpressure();
        run_txn(3'b001, 0, 32'h3000, 8'd2, 5, 0, 1'b0, -1, -1, 1'b0);
        run_txn(3'b001, 0, 32'h3100, 8'd7, 0, 1, 1'b0, -1, -1, 1'b0);
    endtask

    task automatic test_early_last();
        run_txn(3'b010, 1, 32'h4000, 8'd3, 0, 0, 1'b0, 2, -1, 1'b0);
    endtask

    task automatic test_reset_mid();
        run_txn(3'b010, 1, 32'h5000, 8'd3, 0, 0, 1'b0, -1, 2, 1'b0);
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 3'b010 || busy !== 1'b1) begin
            errors++; $display("FAIL mid_data: got rv=%b busy=%b exp 010/1", rsp_valid, busy); end
        rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        @(negedge clk);
        ddr_r_valid = 1'b0; ddr_r_last = 1'b0; rsp_ready = 3'b000;
        rst_n = 1'b1; last_m = 2; err_m = 1'b0;
        run_txn(3'b111, 0, 32'h5100, 8'd1, 0, 0, 1'b0, -1, -1, 1'b0);
    endtask

    task automatic test_pulse_busy();
        run_txn(3'b001, 0, 32'h6000, 8'd3, 0, 0, 1'b0, -1, -1, 1'b1);
        @(negedge clk); #1;
        checks++; if (ddr_ar_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL pulse_no_ar: got ar_v=%b busy=%b exp 0/0", ddr_ar_valid, busy); end
    endtask

    task automatic test_random();
        logic [2:0] r;
        int w;
        for (int t = 0; t < 12; t++) begin
            r = 3'($urandom_range(1, 7));
            w = pick(r, last_m);
            run_txn(r, w, $urandom, 8'($urandom_range(0, 12)), $urandom_range(0, 3), 2, 1'b1, -1, -1, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_early_last();
        test_reset_mid();
        test_pulse_busy();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
